hash_rd: RTL and testbench
==========================

# hash_rd

Digest read-out serializer for the hash core. After a hash operation completes, it captures the 512-bit digest register. It then streams the digest to the host-side interface as 32-bit words under a pull handshake. The final word carries the same byte-size encoding that the hash input buffer accepts on its receive side, so a digest of any byte length from 1 to 64 can be returned.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- hash_m  in  512  digest value; word 0 = hash_m[511:480], word 15 = hash_m[31:0]
- out_len  in  7  digest length in bytes, sampled on h_rd_start
- h_rd_start  in  1  start request
- h_rd_clr  in  1  synchronous abort/clear
- h_rd_rdy  out  1  block idle, start accepted
- rd_en  in  1  consumer pulls current word
- rd_d  out  32  current digest word, MSB byte first
- rd_vld  out  1  rd_d valid
- rd_last  out  1  current word is the final word
- rd_size  out  2  valid bytes in final word: 00 = 4, 01 = 1, 10 = 2, 11 = 3; forced 00 when rd_last = 0
- h_rd_done  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE (h_rd_rdy = 1) and SEND (rd_vld = 1). One-hot encoding: IDLE = 2'b01, SEND = 2'b10.
- IDLE & h_rd_start:
  - Capture hash_m into the 512-bit shadow register dig.
  - Capture the effective length into len. len = 64 if out_len = 0 or out_len > 64; otherwise len = out_len.
  - Clear the byte counter bcnt[6:0]; go to SEND.
- h_rd_start outside IDLE is ignored.
- SEND output:
  - rd_d = dig word at index bcnt[5:2].
  - rem = len − bcnt.
  - rd_last = (rem ≤ 4).
  - rd_size = rem[1:0] when rd_last, else 00.
- Last-word masking: when rd_last and rd_size ≠ 00, bytes beyond rd_size are zero. The mask is {32{1'b1}} >> {rd_size,3'd0}, inverted and ANDed with the word.
- SEND & rd_en:
  - If not rd_last: bcnt += 4.
  - If rd_last: go to IDLE, assert h_rd_done next cycle, clear bcnt.
- rd_en while rd_vld = 0 has no effect.
- h_rd_clr (any state):
  - state → IDLE; bcnt, len, dig ← 0; h_rd_done ← 0.
  - Takes priority over h_rd_start and rd_en in the same cycle.
- hash_m changes after capture do not affect the words in flight.

## Timing
- Reset values: h_rd_rdy = 1, rd_vld = 0, rd_last = 0, rd_size = 00, rd_d = 0, h_rd_done = 0.
- The state register, bcnt, len and dig are all 0 at reset, except that state resets to IDLE.
- rd_d, rd_last and rd_size are combinational from registered state; no input-to-output combinational path except masking.
- h_rd_start at cycle T → rd_vld = 1 at T+1 with word 0.
- One word accepted per cycle when rd_en is held high. A 64-byte digest drains in 16 cycles; h_rd_done pulses at T+17.
- Back-to-back operation: h_rd_rdy rises in the cycle after the last accept, and a new h_rd_start is legal in that cycle.
- A reset deasserted mid-stream returns the block to IDLE with all outputs at their reset values.

## Configuration
- HASH_RD_BSWAP_EN:
  - Defined: each output word is byte-reversed, least-significant digest byte first. Masking is then applied to the upper bytes, so valid bytes stay in rd_d[8*rd_size-1:0].
  - Undefined: MSB-first order as above.
  - Counters, rd_last, rd_size and handshake timing are identical in both builds.

## Structure
- Shared package hash_pkg holds:
  - state localparams IDLE/SEND;
  - DIG_MAX_BYTES = 64;
  - the size encoding constants SZ_FULL = 2'b00, SZ_1 = 2'b01, SZ_2 = 2'b10, SZ_3 = 2'b11, also used by the input buffer.
- One sub-module: hash_byte_mask. It maps (word, last, size) to the masked word and is shared with the input-side masking logic.
- The FSM, counter and shadow register stay in hash_rd.

## Test plan
- Reset, then out_len = 64 with hash_m = {16 words 0x00010203+4k}, rd_en held 1:
  - 16 words 0x00010203 … 0x3C3D3E3F;
  - rd_last only on word 15, rd_size = 00;
  - h_rd_done one cycle after.
- out_len = 48, same digest: 12 words, with rd_last on word 11.
- out_len = 7 with hash_m[511:448] = 0x1122334455667788:
  - 0x11223344 with rd_last = 0;
  - then 0x55667700 with rd_last = 1, rd_size = 11.
- out_len = 0 and out_len = 100 both produce 16 words.
- rd_en toggled 1/0/0/1 with out_len = 64: words are not skipped or repeated, and rd_d holds steady while rd_en = 0.
- h_rd_clr asserted with rd_en = 1 on word 5:
  - next cycle rd_vld = 0, h_rd_rdy = 1, no h_rd_done;
  - a following start replays from word 0.
- h_rd_start during SEND is ignored and bcnt is unchanged.
- With HASH_RD_BSWAP_EN, out_len = 7: words 0x44332211 and 0x00776655, rd_size = 11.

Source files
------------

// File: rtl/hash_pkg.sv
// ----------------------------------------------------------------------------
// hash_pkg
// Shared definitions for the hash core digest path:
//   - one-hot FSM state codes (IDLE / SEND)
//   - maximum digest size in bytes
//   - last-word byte-size encoding, common to the input buffer and the
//     digest read-out serializer
//   - eff_len(): maps a requested digest length to the length actually sent
// ----------------------------------------------------------------------------
package hash_pkg;

   localparam logic [1:0] IDLE = 2'b01;
   localparam logic [1:0] SEND = 2'b10;

   localparam int unsigned DIG_MAX_BYTES = 64;

   // Valid bytes in a final word: 00 means the whole word is valid.
   localparam logic [1:0] SZ_FULL = 2'b00;
   localparam logic [1:0] SZ_1    = 2'b01;
   localparam logic [1:0] SZ_2    = 2'b10;
   localparam logic [1:0] SZ_3    = 2'b11;

   // A zero or out-of-range request returns the full digest.
   function automatic logic [6:0] eff_len(input logic [6:0] req);
      if ((req == 7'd0) || (req > 7'(DIG_MAX_BYTES))) begin
         return 7'(DIG_MAX_BYTES);
      end else begin
         return req;
      end
   endfunction

endpackage

// File: rtl/hash_byte_mask.sv
// ----------------------------------------------------------------------------
// hash_byte_mask
// Zeroes the invalid bytes of a partial final word.
// Ports:
//   word_i  [31:0] in   word before masking
//   last_i         in   word is the final word of the transfer
//   size_i  [1:0]  in   valid-byte encoding (SZ_FULL = all 4 bytes)
//   word_o  [31:0] out  masked word
// Parameter LSB_FIRST selects where the valid bytes sit: 0 keeps the upper
// bytes (MSB-first order), 1 keeps the lower bytes (byte-reversed order).
// ----------------------------------------------------------------------------
module hash_byte_mask
   import hash_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic [31:0] word_i,
   input  logic        last_i,
   input  logic [1:0]  size_i,
   output logic [31:0] word_o
);

   logic [31:0] keep_s;

   // Build the byte keep-mask and apply it.
   always_comb begin
      keep_s = 32'hFFFF_FFFF;
      if (last_i && (size_i != SZ_FULL)) begin
         if (LSB_FIRST) begin
            keep_s = ~(32'hFFFF_FFFF << {size_i, 3'd0});
         end else begin
            keep_s = ~(32'hFFFF_FFFF >> {size_i, 3'd0});
         end
      end else begin
         keep_s = 32'hFFFF_FFFF;
      end
      word_o = word_i & keep_s;
   end

endmodule

// File: rtl/hash_rd.sv
// ----------------------------------------------------------------------------
// hash_rd
// Digest read-out serializer. On h_rd_start it snapshots the 512-bit digest
// and the effective length, then streams 32-bit words under a pull handshake
// (rd_vld / rd_en). The final word carries a byte-size code so any length
// from 1 to 64 bytes can be returned.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   hash_m     [511:0]  digest (word 0 = hash_m[511:480])
//   out_len    [6:0]    requested length in bytes, sampled on h_rd_start
//   h_rd_start          start request (ignored unless idle)
//   h_rd_clr            synchronous abort/clear, highest priority
//   h_rd_rdy            idle, start accepted
//   rd_en               consumer pulls current word
//   rd_d       [31:0]   current word
//   rd_vld              rd_d valid
//   rd_last             current word is the final one
//   rd_size    [1:0]    valid bytes in final word (00 = 4), 00 when not last
//   h_rd_done           one-cycle pulse after the final word is accepted
// Build option: define HASH_RD_BSWAP_EN to emit each word byte-reversed
// (least-significant digest byte first, valid bytes in the low lanes).
// ----------------------------------------------------------------------------
module hash_rd (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [511:0] hash_m,
   input  logic [6:0]   out_len,
   input  logic         h_rd_start,
   input  logic         h_rd_clr,
   output logic         h_rd_rdy,
   input  logic         rd_en,
   output logic [31:0]  rd_d,
   output logic         rd_vld,
   output logic         rd_last,
   output logic [1:0]   rd_size,
   output logic         h_rd_done
);
   import hash_pkg::*;

   logic [1:0]   state_q, state_d;
   logic [511:0] dig_q,   dig_d;
   logic [6:0]   len_q,   len_d;
   logic [6:0]   bcnt_q,  bcnt_d;
   logic         done_q,  done_d;

   logic [6:0]   rem_s;
   logic [8:0]   base_s;
   logic [31:0]  word_s;
   logic [31:0]  word_ord_s;
   logic         last_s;
   logic [1:0]   size_s;

   // State register plus counter, length and digest shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dig_q   <= 512'd0;
         len_q   <= 7'd0;
         bcnt_q  <= 7'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         len_q   <= len_d;
         bcnt_q  <= bcnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: clear beats start and pull in the same cycle.
   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      len_d   = len_q;
      bcnt_d  = bcnt_q;
      done_d  = 1'b0;
      if (h_rd_clr) begin
         state_d = IDLE;
         dig_d   = 512'd0;
         len_d   = 7'd0;
         bcnt_d  = 7'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (h_rd_start) begin
                  dig_d   = hash_m;
                  len_d   = eff_len(out_len);
                  bcnt_d  = 7'd0;
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
               end
            end
            SEND: begin
               if (rd_en && last_s) begin
                  state_d = IDLE;
                  bcnt_d  = 7'd0;
                  done_d  = 1'b1;
               end else if (rd_en) begin
                  bcnt_d  = bcnt_q + 7'd4;
               end else begin
                  state_d = SEND;
               end
            end
            default: begin
               state_d = IDLE;
               bcnt_d  = 7'd0;
            end
         endcase
      end
   end

   // Output decode from registered state only.
   always_comb begin
      rem_s    = len_q - bcnt_q;
      // Word index bcnt[5:2] counts from the top of the digest: 15 - idx.
      base_s   = {~bcnt_q[5:2], 5'd0};
      word_s   = 32'd0;
      last_s   = 1'b0;
      size_s   = SZ_FULL;
      h_rd_rdy = (state_q == IDLE);
      rd_vld   = (state_q == SEND);
      if (state_q == SEND) begin
         word_s = dig_q[base_s +: 32];
         last_s = (rem_s <= 7'd4);
         size_s = last_s ? rem_s[1:0] : SZ_FULL;
      end else begin
         word_s = 32'd0;
         last_s = 1'b0;
         size_s = SZ_FULL;
      end
      rd_last   = last_s;
      rd_size   = size_s;
      h_rd_done = done_q;
   end

`ifdef HASH_RD_BSWAP_EN
   assign word_ord_s = {word_s[7:0], word_s[15:8], word_s[23:16], word_s[31:24]};

   hash_byte_mask #(.LSB_FIRST(1'b1)) u_mask (
      .word_i (word_ord_s),
      .last_i (last_s),
      .size_i (size_s),
      .word_o (rd_d)
   );
`else
   assign word_ord_s = word_s;

   hash_byte_mask #(.LSB_FIRST(1'b0)) u_mask (
      .word_i (word_ord_s),
      .last_i (last_s),
      .size_i (size_s),
      .word_o (rd_d)
   );
`endif

endmodule

// File: tb/tb_hash_rd.sv
// ----------------------------------------------------------------------------
// tb_hash_rd
// Directed bench for hash_rd. Expected words are built byte-by-byte from the
// digest and length and queued at start; each presented word is checked
// against the queue head and popped when the bench pulls it.
// ----------------------------------------------------------------------------
module tb_hash_rd;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [511:0] hash_m = 512'd0;
   logic [6:0]   out_len = 7'd0;
   logic         h_rd_start = 1'b0;
   logic         h_rd_clr = 1'b0;
   logic         rd_en = 1'b0;
   logic         h_rd_rdy;
   logic [31:0]  rd_d;
   logic         rd_vld;
   logic         rd_last;
   logic [1:0]   rd_size;
   logic         h_rd_done;

   typedef struct packed {
      logic [31:0] d;
      logic        last;
      logic [1:0]  size;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

`ifdef HASH_RD_BSWAP_EN
   localparam bit BSWAP = 1'b1;
`else
   localparam bit BSWAP = 1'b0;
`endif

   hash_rd dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hash_m     (hash_m),
      .out_len    (out_len),
      .h_rd_start (h_rd_start),
      .h_rd_clr   (h_rd_clr),
      .h_rd_rdy   (h_rd_rdy),
      .rd_en      (rd_en),
      .rd_d       (rd_d),
      .rd_vld     (rd_vld),
      .rd_last    (rd_last),
      .rd_size    (rd_size),
      .h_rd_done  (h_rd_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      check({p, "_rdy"},  {31'd0, h_rd_rdy},  32'd1);
      check({p, "_vld"},  {31'd0, rd_vld},    32'd0);
      check({p, "_last"}, {31'd0, rd_last},   32'd0);
      check({p, "_size"}, {30'd0, rd_size},   32'd0);
      check({p, "_data"}, rd_d,               32'd0);
      check({p, "_done"}, {31'd0, h_rd_done}, 32'd0);
   endtask

   // Reference: queue every expected word for one transfer.
   task automatic push_model(input logic [511:0] dig, input logic [6:0] olen);
      int         len;
      int         nw;
      int         n;
      exp_t       e;
      logic [7:0] b;
      len = ((olen == 7'd0) || (olen > 7'd64)) ? 64 : int'(olen);
      nw  = (len + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         e = '0;
         for (int j = 0; j < 4; j++) begin
            if ((4 * k + j) < len) begin
               b = dig[511 - 8 * (4 * k + j) -: 8];
               if (BSWAP) e.d[8 * j +: 8] = b;
               else       e.d[31 - 8 * j -: 8] = b;
            end
         end
         n      = len - 4 * k;
         e.last = (k == nw - 1);
         e.size = (e.last && (n < 4)) ? n[1:0] : 2'b00;
         sb.push_back(e);
      end
   endtask

   task automatic start(input logic [511:0] dig, input logic [6:0] olen);
      check("rdy_before_start", {31'd0, h_rd_rdy}, 32'd1);
      hash_m     = dig;
      out_len    = olen;
      h_rd_start = 1'b1;
      push_model(dig, olen);
      @(posedge clk);
      @(negedge clk);
      h_rd_start = 1'b0;
      hash_m     = ~dig;   // must not disturb the captured digest
      check("done_low_in_send", {31'd0, h_rd_done}, 32'd0);
      check("rdy_low_in_send",  {31'd0, h_rd_rdy},  32'd0);
   endtask

   // Pull the queued words. abort_at: clear on that word. ign_at: issue a
   // stray start on that word. toggle: rd_en pattern 1/0/0/1.
   task automatic stream(input int abort_at, input int ign_at, input bit toggle, output int cyc);
      int   idx = 0;
      int   ph = 0;
      bit   en;
      bit   ign_done = 1'b0;
      exp_t e;
      cyc = 0;
      while ((sb.size() > 0) && (cyc < 200)) begin
         e = sb[0];
         check($sformatf("vld_w%0d", idx),  {31'd0, rd_vld},  32'd1);
         check($sformatf("data_w%0d", idx), rd_d,             e.d);
         check($sformatf("last_w%0d", idx), {31'd0, rd_last}, {31'd0, e.last});
         check($sformatf("size_w%0d", idx), {30'd0, rd_size}, {30'd0, e.size});
         h_rd_start = 1'b0;
         if (idx == abort_at) begin
            h_rd_clr = 1'b1;
            rd_en    = 1'b1;
            h_rd_start = 1'b1;
            sb.delete();
            @(posedge clk);
            @(negedge clk);
            h_rd_clr   = 1'b0;
            h_rd_start = 1'b0;
            rd_en      = 1'b0;
            check("clr_vld",  {31'd0, rd_vld},    32'd0);
            check("clr_rdy",  {31'd0, h_rd_rdy},  32'd1);
            check("clr_done", {31'd0, h_rd_done}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("clr_done_later", {31'd0, h_rd_done}, 32'd0);
            cyc = -1;
            return;
         end
         if ((idx == ign_at) && !ign_done) begin
            h_rd_start = 1'b1;
            out_len    = 7'd4;
            ign_done   = 1'b1;
         end
         en = toggle ? (((ph % 4) == 0) || ((ph % 4) == 3)) : 1'b1;
         ph++;
         rd_en = en;
         if (en) begin
            void'(sb.pop_front());
            idx++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      rd_en      = 1'b0;
      h_rd_start = 1'b0;
      check("stream_drained", sb.size(), 32'd0);
      check("done_pulse",     {31'd0, h_rd_done}, 32'd1);
      check("end_vld",        {31'd0, rd_vld},    32'd0);
      check("end_rdy",        {31'd0, h_rd_rdy},  32'd1);
   endtask

   logic [511:0] dig_a;
   logic [511:0] dig_b;
   logic [511:0] dig_c;
   int           cyc;

   initial begin
      for (int i = 0; i < 64; i++) dig_a[511 - 8 * i -: 8] = 8'(i);
      dig_b = {64'h1122_3344_5566_7788, {14{32'hA5A5_5A5A}}};
      for (int i = 0; i < 16; i++) dig_c[32 * i +: 32] = $urandom();

      // Reset state
      repeat (2) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset("post_rst");

      // Full 64-byte digest at full rate, done at T+17
      start(dig_a, 7'd64);
      stream(-1, -1, 1'b0, cyc);
      check("latency_64", cyc, 32'd16);

      // Back-to-back: 48 bytes
      start(dig_a, 7'd48);
      stream(-1, -1, 1'b0, cyc);
      check("latency_48", cyc, 32'd12);

      // 7 bytes: partial last word
      start(dig_b, 7'd7);
      stream(-1, -1, 1'b0, cyc);
      check("latency_7", cyc, 32'd2);

      // Out-of-range lengths map to the full digest
      start(dig_a, 7'd0);
      stream(-1, -1, 1'b0, cyc);
      check("latency_len0", cyc, 32'd16);
      start(dig_c, 7'd100);
      stream(-1, -1, 1'b0, cyc);
      check("latency_len100", cyc, 32'd16);

      // Single byte
      start(dig_c, 7'd1);
      stream(-1, -1, 1'b0, cyc);

      // Throttled pull
      start(dig_a, 7'd64);
      stream(-1, -1, 1'b1, cyc);

      // Clear on word 5, then replay from word 0
      start(dig_a, 7'd64);
      stream(5, -1, 1'b0, cyc);
      start(dig_a, 7'd64);
      stream(-1, -1, 1'b0, cyc);

      // Stray start mid-transfer is ignored
      start(dig_c, 7'd64);
      stream(-1, 3, 1'b0, cyc);
      check("latency_ign", cyc, 32'd16);

      // Reset asserted mid-stream
      start(dig_a, 7'd64);
      rd_en = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset("mid_rst");
      rd_en = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset("after_mid_rst");

      start(dig_b, 7'd5);
      stream(-1, -1, 1'b0, cyc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
